// File: rtl/axi_vip_slave.sv
// AXI3/4-style memory slave model: one outstanding write and one outstanding read,
// backed by four byte-lane arrays that testbenches may load/peek hierarchically.
module axi_vip_slave #(
    parameter int ID                = 0,
    parameter int MEM_SIZE          = 2**17,
    parameter int AXI_AXID_WIDTH    = 6,
    parameter int AXI_AXADDR_WIDTH  = 32,
    parameter int AXI_AXLEN_WIDTH   = 8,
    parameter int AXI_AXSIZE_WIDTH  = 3,
    parameter int AXI_AXBURST_WIDTH = 2,
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_RESP_WIDTH    = 2
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [AXI_AXID_WIDTH-1:0]     s_awid,
    input  logic [AXI_AXADDR_WIDTH-1:0]   s_awaddr,
    input  logic [AXI_AXLEN_WIDTH-1:0]    s_awlen,
    input  logic [AXI_AXSIZE_WIDTH-1:0]   s_awsize,
    input  logic [AXI_AXBURST_WIDTH-1:0]  s_awburst,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                          s_wlast,
    input  logic                          s_wvalid,
    output logic                          s_wready,
    output logic [AXI_AXID_WIDTH-1:0]     s_bid,
    output logic [AXI_RESP_WIDTH-1:0]     s_bresp,
    output logic                          s_bvalid,
    input  logic                          s_bready,
    input  logic [AXI_AXID_WIDTH-1:0]     s_arid,
    input  logic [AXI_AXADDR_WIDTH-1:0]   s_araddr,
    input  logic [AXI_AXLEN_WIDTH-1:0]    s_arlen,
    input  logic [AXI_AXSIZE_WIDTH-1:0]   s_arsize,
    input  logic [AXI_AXBURST_WIDTH-1:0]  s_arburst,
    input  logic                          s_arvalid,
    output logic                          s_arready,
    output logic [AXI_AXID_WIDTH-1:0]     s_rid,
    output logic [AXI_DATA_WIDTH-1:0]     s_rdata,
    output logic [AXI_RESP_WIDTH-1:0]     s_rresp,
    output logic                          s_rlast,
    output logic                          s_rvalid,
    input  logic                          s_rready
);
    localparam int AW   = AXI_AXADDR_WIDTH;
    localparam int IDXW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [7:0] mem_byte0 [MEM_SIZE];
    logic [7:0] mem_byte1 [MEM_SIZE];
    logic [7:0] mem_byte2 [MEM_SIZE];
    logic [7:0] mem_byte3 [MEM_SIZE];

    w_state_t                      w_state, w_next;
    r_state_t                      r_state, r_next;
    logic                          alive;
    logic [AXI_AXID_WIDTH-1:0]     aw_id_q, ar_id_q;
    logic [AW-1:0]                 aw_addr_q, ar_addr_q;
    logic [AXI_AXLEN_WIDTH-1:0]    aw_len_q, ar_len_q, w_cnt, r_cnt;
    logic [AXI_AXSIZE_WIDTH-1:0]   aw_size_q, ar_size_q;
    logic [AXI_AXBURST_WIDTH-1:0]  aw_burst_q, ar_burst_q;
    logic                          aw_hs, w_hs, ar_hs, r_hs;
    logic [IDXW-1:0]               w_idx, r_idx;
    logic                          unused_ok;

    // s_wlast is ignored (burst end comes from the beat count); ID is a sim-only tag.
    assign unused_ok = &{1'b0, s_wlast, ID[0]};

    function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] addr);
        return IDXW'((addr >> 2) % AW'(MEM_SIZE));
    endfunction

    // WRAP keeps the bits above the (len+1)<<size block and wraps the bits below it.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0]                addr,
                                                input logic [AXI_AXSIZE_WIDTH-1:0]  size,
                                                input logic [AXI_AXLEN_WIDTH-1:0]   len,
                                                input logic [AXI_AXBURST_WIDTH-1:0] burst);
        logic [AW-1:0] incr, mask;
        incr = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            AXI_AXBURST_WIDTH'(0): next_addr = addr;
            AXI_AXBURST_WIDTH'(2): next_addr = (addr & ~mask) | ((addr + incr) & mask);
            default:               next_addr = addr + incr;
        endcase
    endfunction

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;
    assign w_idx = word_idx(aw_addr_q);
    assign r_idx = word_idx(ar_addr_q);

    always_comb begin
        w_next    = w_state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_awready = alive;
                if (s_awvalid && alive) w_next = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid && w_cnt == aw_len_q) w_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next    = r_state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rlast   = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_arready = alive;
                if (s_arvalid && alive) r_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                s_rlast  = (r_cnt == ar_len_q);
                if (s_rready && s_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign s_bid   = aw_id_q;
    assign s_bresp = '0;
    assign s_rid   = ar_id_q;
    assign s_rresp = '0;
    assign s_rdata = {mem_byte3[r_idx], mem_byte2[r_idx], mem_byte1[r_idx], mem_byte0[r_idx]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            alive      <= 1'b0;
            w_state    <= W_IDLE;
            r_state    <= R_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt      <= '0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt      <= '0;
        end else begin
            alive   <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
            if (aw_hs) begin
                aw_id_q    <= s_awid;
                aw_addr_q  <= s_awaddr;
                aw_len_q   <= s_awlen;
                aw_size_q  <= s_awsize;
                aw_burst_q <= s_awburst;
                w_cnt      <= '0;
            end else if (w_hs) begin
                aw_addr_q <= next_addr(aw_addr_q, aw_size_q, aw_len_q, aw_burst_q);
                w_cnt     <= w_cnt + AXI_AXLEN_WIDTH'(1);
            end
            if (ar_hs) begin
                ar_id_q    <= s_arid;
                ar_addr_q  <= s_araddr;
                ar_len_q   <= s_arlen;
                ar_size_q  <= s_arsize;
                ar_burst_q <= s_arburst;
                r_cnt      <= '0;
            end else if (r_hs) begin
                ar_addr_q <= next_addr(ar_addr_q, ar_size_q, ar_len_q, ar_burst_q);
                r_cnt     <= r_cnt + AXI_AXLEN_WIDTH'(1);
            end
        end
    end

    // Storage survives reset; the read port is combinational so same-cycle reads see old data.
    always_ff @(posedge aclk) begin
        if (w_hs) begin
            if (s_wstrb[0]) mem_byte0[w_idx] <= s_wdata[7:0];
            if (s_wstrb[1]) mem_byte1[w_idx] <= s_wdata[15:8];
            if (s_wstrb[2]) mem_byte2[w_idx] <= s_wdata[23:16];
            if (s_wstrb[3]) mem_byte3[w_idx] <= s_wdata[31:24];
        end
    end
endmodule

// File: tb/tb_axi_vip_slave.sv
// Directed bench for axi_vip_slave: table of single writes plus hand-written burst,
// wrap, stall, concurrency and mid-burst reset sequences.
module tb_axi_vip_slave;
    localparam int MEM = 256;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [5:0]  s_awid = '0, s_arid = '0, s_bid, s_rid;
    logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0, s_rdata;
    logic [7:0]  s_awlen = '0, s_arlen = '0;
    logic [2:0]  s_awsize = '0, s_arsize = '0;
    logic [1:0]  s_awburst = '0, s_arburst = '0, s_bresp, s_rresp;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wlast = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
    logic        s_arvalid = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rlast, s_rvalid;

    int checks = 0;
    int errors = 0;

    axi_vip_slave #(.ID(3), .MEM_SIZE(MEM)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          word;
        logic [31:0] exp;
    } wvec_t;

    wvec_t tv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] peek(input int w);
        return {dut.mem_byte3[w], dut.mem_byte2[w], dut.mem_byte1[w], dut.mem_byte0[w]};
    endfunction

    task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge aclk);
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        while (!s_awready && n < 20) begin @(negedge aclk); n++; end
        chk("aw_ready", {31'b0, s_awready}, 32'd1);
        @(posedge aclk); #1 s_awvalid = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] data [16], input logic [3:0] strb [16]);
        aw_send(id, addr, len, size, burst);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge aclk);
            s_wvalid = 1'b1; s_wdata = data[b]; s_wstrb = strb[b]; s_wlast = (b == int'(len));
            chk("w_ready", {31'b0, s_wready}, 32'd1);
            @(posedge aclk); #1 s_wvalid = 1'b0; s_wlast = 1'b0;
        end
        @(negedge aclk);
        chk("b_valid", {31'b0, s_bvalid}, 32'd1);
        chk("b_id", {26'b0, s_bid}, {26'b0, id});
        chk("b_resp", {30'b0, s_bresp}, 32'd0);
        s_bready = 1'b1;
        @(posedge aclk); #1 s_bready = 1'b0;
    endtask

    task automatic w_single(input logic [5:0] id, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] d [16];
        logic [3:0]  s [16];
        d[0] = data; s[0] = strb;
        do_write(id, addr, 8'd0, 3'd2, 2'b01, d, s);
    endtask

    // stall >= 0 drops rready for two cycles on that beat.
    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] exp [16], input int stall);
        int n = 0;
        @(negedge aclk);
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        while (!s_arready && n < 20) begin @(negedge aclk); n++; end
        chk("ar_ready", {31'b0, s_arready}, 32'd1);
        @(posedge aclk); #1 s_arvalid = 1'b0; s_rready = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge aclk);
            chk("r_valid", {31'b0, s_rvalid}, 32'd1);
            chk("r_data", s_rdata, exp[b]);
            chk("r_last", {31'b0, s_rlast}, {31'b0, b == int'(len)});
            chk("r_id", {26'b0, s_rid}, {26'b0, id});
            if (b == stall) begin
                s_rready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(negedge aclk);
                    chk("r_hold_data", s_rdata, exp[b]);
                    chk("r_hold_last", {31'b0, s_rlast}, {31'b0, b == int'(len)});
                    chk("r_hold_valid", {31'b0, s_rvalid}, 32'd1);
                end
                s_rready = 1'b1;
            end
        end
        @(negedge aclk);
        chk("r_done_valid", {31'b0, s_rvalid}, 32'd0);
        chk("r_done_arready", {31'b0, s_arready}, 32'd1);
        s_rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d [16];
        logic [3:0]  s [16];
        logic [31:0] e [16];

        tv[0] = '{6'h11, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 4, 32'hCAFE_BABE};
        tv[1] = '{6'h12, 32'h0000_0014, 32'h1122_3344, 4'hF, 5, 32'h1122_3344};
        tv[2] = '{6'h13, 32'h0000_0014, 32'hAABB_CCDD, 4'h5, 5, 32'h11BB_33DD};
        tv[3] = '{6'h14, 32'h0000_0017, 32'h9900_0000, 4'h8, 5, 32'h99BB_33DD};
        tv[4] = '{6'h3F, 32'h0000_0410, 32'h1234_5678, 4'h3, 4, 32'hCAFE_5678};
        tv[5] = '{6'h00, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 4, 32'hCAFE_5678};

        #12;
        chk("rst_awready", {31'b0, s_awready}, 32'd0);
        chk("rst_arready", {31'b0, s_arready}, 32'd0);
        chk("rst_wready", {31'b0, s_wready}, 32'd0);
        chk("rst_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, s_rvalid}, 32'd0);
        chk("rst_rlast", {31'b0, s_rlast}, 32'd0);
        chk("rst_ids", {20'b0, s_bid, s_rid}, 32'd0);
        chk("rst_resps", {28'b0, s_bresp, s_rresp}, 32'd0);
        @(negedge aclk); aresetn = 1'b1;
        #1 chk("rel_awready_pre_edge", {31'b0, s_awready}, 32'd0);
        @(negedge aclk);
        chk("rel_awready", {31'b0, s_awready}, 32'd1);
        chk("rel_arready", {31'b0, s_arready}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            w_single(tv[i].id, tv[i].addr, tv[i].data, tv[i].strb);
            chk($sformatf("tv%0d_mem", i), peek(tv[i].word), tv[i].exp);
            e[0] = tv[i].exp;
            do_read(tv[i].id, tv[i].addr, 8'd0, 3'd2, 2'b01, e, -1);
        end

        for (int b = 0; b < 4; b++) begin d[b] = 32'(b + 1); s[b] = 4'hF; end
        do_write(6'h21, 32'h100, 8'd3, 3'd2, 2'b01, d, s);
        for (int b = 0; b < 4; b++) chk($sformatf("incr_w_mem%0d", b), peek(64 + b), 32'(b + 1));

        d[0] = 32'h0000_000A; d[1] = 32'h0000_000B;
        do_write(6'h22, 32'h20, 8'd1, 3'd2, 2'b00, d, s);
        chk("fixed_w_mem8", peek(8), 32'h0000_000B);
        chk("fixed_w_mem9", peek(9), 32'h0000_0000);

        e[0] = 1; e[1] = 2; e[2] = 3; e[3] = 4;
        do_read(6'h2A, 32'h100, 8'd3, 3'd2, 2'b01, e, -1);
        e[0] = 3; e[1] = 4; e[2] = 1; e[3] = 2;
        do_read(6'h15, 32'h108, 8'd3, 3'd2, 2'b10, e, -1);
        e[0] = 1; e[1] = 2; e[2] = 3; e[3] = 4;
        do_read(6'h05, 32'h100, 8'd3, 3'd2, 2'b01, e, 1);
        e[0] = 2; e[1] = 2; e[2] = 2;
        do_read(6'h06, 32'h104, 8'd2, 3'd2, 2'b00, e, -1);

        // AW and AR together, then W and R beat to the same word in one cycle.
        @(negedge aclk);
        s_awid = 6'h07; s_awaddr = 32'h100; s_awlen = 0; s_awsize = 2; s_awburst = 1; s_awvalid = 1;
        s_arid = 6'h09; s_araddr = 32'h100; s_arlen = 0; s_arsize = 2; s_arburst = 1; s_arvalid = 1;
        chk("cc_awready", {31'b0, s_awready}, 32'd1);
        chk("cc_arready", {31'b0, s_arready}, 32'd1);
        @(posedge aclk); #1 s_awvalid = 0; s_arvalid = 0;
        @(negedge aclk);
        chk("cc_awready_busy", {31'b0, s_awready}, 32'd0);
        chk("cc_arready_busy", {31'b0, s_arready}, 32'd0);
        chk("cc_rvalid", {31'b0, s_rvalid}, 32'd1);
        s_wvalid = 1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF; s_wlast = 1; s_rready = 1;
        chk("cc_rdata_prewrite", s_rdata, 32'd1);
        @(posedge aclk);
        chk("cc_rdata_at_edge", s_rdata, 32'd1);
        #1 s_wvalid = 0; s_wlast = 0; s_rready = 0;
        @(negedge aclk);
        chk("cc_bvalid", {31'b0, s_bvalid}, 32'd1);
        chk("cc_bid", {26'b0, s_bid}, 32'h07);
        chk("cc_rvalid_done", {31'b0, s_rvalid}, 32'd0);
        chk("cc_mem", peek(64), 32'h7777_7777);
        s_bready = 1;
        @(posedge aclk); #1 s_bready = 0;

        // Reset in the middle of a 4-beat write after two beats.
        aw_send(6'h33, 32'h300, 8'd3, 3'd2, 2'b01);
        for (int b = 0; b < 2; b++) begin
            @(negedge aclk);
            s_wvalid = 1; s_wdata = 32'hA0 + 32'(b); s_wstrb = 4'hF;
            @(posedge aclk); #1 s_wvalid = 0;
        end
        @(negedge aclk); #2 aresetn = 1'b0;
        #1;
        chk("mrst_awready", {31'b0, s_awready}, 32'd0);
        chk("mrst_wready", {31'b0, s_wready}, 32'd0);
        chk("mrst_bvalid", {31'b0, s_bvalid}, 32'd0);
        chk("mrst_bid", {26'b0, s_bid}, 32'd0);
        @(negedge aclk); @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        chk("mrst_awready_rel", {31'b0, s_awready}, 32'd1);
        chk("mrst_bvalid_rel", {31'b0, s_bvalid}, 32'd0);
        chk("mrst_wready_rel", {31'b0, s_wready}, 32'd0);
        chk("mrst_mem0", peek(192), 32'h0000_00A0);
        chk("mrst_mem1", peek(193), 32'h0000_00A1);
        chk("mrst_keep_other", peek(4), 32'hCAFE_5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/axi_vip_slave.md
AXI_VIP_SLAVE -- requirements
Module: axi_vip_slave

Interface
REQ-001 SHALL have parameter ID, default 0, instance tag used only in simulation messages, no functional effect.
REQ-002 SHALL have parameter MEM_SIZE, default 2**17, depth in 32-bit words.
REQ-003 SHALL have parameters AXI_AXID_WIDTH 6, AXI_AXADDR_WIDTH 32, AXI_AXLEN_WIDTH 8, AXI_AXSIZE_WIDTH 3, AXI_AXBURST_WIDTH 2, AXI_DATA_WIDTH 32 (only 32 supported), AXI_RESP_WIDTH 2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: aclk input 1 (rising-edge clock); aresetn input 1 (async active-low reset).
REQ-005 SHALL have AW ports: s_awid in IDW, s_awaddr in AW, s_awlen in LENW, s_awsize in SZW, s_awburst in BW, s_awvalid in 1, s_awready out 1.
REQ-006 SHALL have W ports: s_wdata in 32, s_wstrb in 4, s_wlast in 1, s_wvalid in 1, s_wready out 1.
REQ-007 SHALL have B ports: s_bid out IDW, s_bresp out 2, s_bvalid out 1, s_bready in 1.
REQ-008 SHALL have AR ports: s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid (inputs, same widths as AW), s_arready out 1.
REQ-009 SHALL have R ports: s_rid out IDW, s_rdata out 32, s_rresp out 2, s_rlast out 1, s_rvalid out 1, s_rready in 1.
REQ-010 SHALL hold storage in four byte arrays named mem_byte0..mem_byte3 (8 bits x MEM_SIZE), byte k = data bits [8k+7:8k], hierarchically accessible for backdoor load/peek/poke.

Function
REQ-011 Word index SHALL be (addr >> 2) modulo MEM_SIZE; addr[1:0] ignored for indexing.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; read FSM R_IDLE, R_DATA; the two run independently and concurrently.
REQ-013 W_IDLE: s_awready=1; on awvalid&awready latch id/addr/len/size/burst, beat count=0, go W_DATA next cycle.
REQ-014 W_DATA: s_wready=1; each wvalid&wready SHALL write byte lane k where s_wstrb[k]=1, leave others untouched, then advance address.
REQ-015 Burst end SHALL be beat count==len (s_wlast ignored for termination); then go W_RESP.
REQ-016 W_RESP: s_bvalid=1, s_bid=latched id, s_bresp=2'b00; hold until s_bready, then W_IDLE; awready low outside W_IDLE (one outstanding write).
REQ-017 R_IDLE: s_arready=1; on arvalid&arready latch fields, go R_DATA next cycle.
REQ-018 R_DATA: s_rvalid=1, s_rid=latched id, s_rresp=2'b00, s_rdata=full word at current address read combinationally from arrays, s_rlast=1 iff count==len; on rvalid&rready advance; after last beat go R_IDLE; arready low outside R_IDLE.
REQ-019 Address advance: FIXED(00) unchanged; INCR(01) addr+(1<<size); WRAP(10) addr+(1<<size) wrapped within aligned block of (len+1)<<size bytes; reserved(11) treated as INCR.
REQ-020 Narrow transfers SHALL use the same word lanes (no data shifting); bus is always 32-bit word-aligned.
REQ-021 Outputs SHALL hold stable while valid and not accepted; read/write of same word in same cycle: read returns pre-write data.
REQ-022 Latency: first R beat 1 cycle after AR handshake; B 1 cycle after last W handshake; one beat per cycle when ready held high.

Reset
REQ-023 While aresetn=0 all ready/valid outputs, s_rlast, s_bid, s_rid, s_bresp, s_rresp SHALL be 0 and FSMs in W_IDLE/R_IDLE; after release awready/arready assert on first aclk edge.
REQ-024 Memory arrays SHALL NOT be cleared by reset; reset mid-burst SHALL abort it, keeping bytes already written.

Verification
REQ-025 Single write addr 0x10, data 0xCAFEBABE, strb 0xF, len 0 -> mem word 4 = 0xCAFEBABE, bvalid 1 cycle after W, bresp 00, bid echoed.
REQ-026 Backdoor word 5=0x11223344; write strb 0x5 data 0xAABBCCDD to 0x14 -> word 5 = 0x11BB33DD.
REQ-027 INCR read len 3 size 2 from 0x100 preloaded 1,2,3,4 -> rdata 1,2,3,4, rlast only on 4th beat, rid echoed.
REQ-028 WRAP read len 3 size 2 from 0x108 -> words at 0x108,0x10C,0x100,0x104.
REQ-029 rready toggled low mid-burst -> rdata/rlast held, no beat lost; concurrent AW/AR accepted same cycle.
REQ-030 aresetn low mid write burst -> bvalid 0, awready 1 after release, earlier beats retained.
